l1_data_cache: RTL and testbench

//  Direct-mapped, write-back, write-allocate L1 cache. Responder to the pipeline's 16-bit

---
 rtl/l1_data_cache.sv | 135 +++++++++++++
 tb/tb_l1_data_cache.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_data_cache.sv
// Direct-mapped, write-back, write-allocate L1 data cache: 8 sets of 128-bit lines, 9-bit tags.
// CPU side is a 16-bit held-request port; memory side moves whole lines to/from pmem.
module l1_data_cache (
    input  logic         clk,
    input  logic         rst,
    input  logic [15:0]  mem_address,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [1:0]   mem_wmask,
    input  logic [15:0]  mem_wdata,
    output logic [15:0]  mem_rdata,
    output logic         mem_resp,
    output logic [15:0]  pmem_address,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [127:0] data_arr [8];
    logic [8:0]   tag_arr  [8];
    logic [7:0]   valid;
    logic [7:0]   dirty;

    // Miss set and tag are captured on the miss so pmem outputs stay fixed
    // for the whole transaction even if the CPU changes or drops its request.
    logic [8:0]   miss_tag;
    logic [2:0]   miss_idx;

    logic [8:0]   addr_tag;
    logic [2:0]   addr_idx;
    logic [2:0]   word_sel;
    logic         addr_unused;
    logic         request;
    logic         hit;
    logic         hit_we;
    logic         fill_we;
    logic [127:0] hit_line;
    logic [127:0] merged_line;

    assign addr_tag    = mem_address[15:7];
    assign addr_idx    = mem_address[6:4];
    assign word_sel    = mem_address[3:1];
    assign addr_unused = mem_address[0];
    assign request     = mem_read | mem_write;
    assign hit         = valid[addr_idx] && (tag_arr[addr_idx] == addr_tag);
    assign hit_line    = data_arr[addr_idx];
    assign hit_we      = (state == IDLE) && mem_write && hit;
    assign fill_we     = (state == ALLOCATE) && pmem_resp;

    always_comb begin
        merged_line = hit_line;
        if (mem_wmask[0]) merged_line[{word_sel, 4'b0000} +: 8] = mem_wdata[7:0];
        if (mem_wmask[1]) merged_line[{word_sel, 4'b1000} +: 8] = mem_wdata[15:8];
    end

    always_comb begin
        state_next   = state;
        mem_resp     = 1'b0;
        mem_rdata    = 16'h0000;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = 16'h0000;
        pmem_wdata   = 128'h0;
        case (state)
            IDLE: begin
                if (request) begin
                    if (hit) begin
                        mem_resp = 1'b1;
                        // A simultaneous read+write is serviced as a write.
                        if (!mem_write) mem_rdata = hit_line[{word_sel, 4'b0000} +: 16];
                    end else if (dirty[addr_idx]) begin
                        state_next = WRITEBACK;
                    end else begin
                        state_next = ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_arr[miss_idx], miss_idx, 4'b0000};
                pmem_wdata   = data_arr[miss_idx];
                if (pmem_resp) state_next = ALLOCATE;
            end
            ALLOCATE: begin
                pmem_read    = 1'b1;
                pmem_address = {miss_tag, miss_idx, 4'b0000};
                if (pmem_resp) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            valid    <= 8'h00;
            dirty    <= 8'h00;
            miss_tag <= 9'h000;
            miss_idx <= 3'd0;
        end else begin
            state <= state_next;
            if ((state == IDLE) && request && !hit) begin
                miss_tag <= addr_tag;
                miss_idx <= addr_idx;
            end
            if (hit_we && (mem_wmask != 2'b00)) dirty[addr_idx] <= 1'b1;
            if ((state == WRITEBACK) && pmem_resp) dirty[miss_idx] <= 1'b0;
            if (fill_we) begin
                valid[miss_idx] <= 1'b1;
                dirty[miss_idx] <= 1'b0;
            end
        end
    end

    // Tag and data storage carry no reset; valid bits gate their use.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            data_arr[miss_idx] <= pmem_rdata;
            tag_arr[miss_idx]  <= miss_tag;
        end else if (hit_we) begin
            data_arr[addr_idx] <= merged_line;
        end
    end

endmodule

// File: tb/tb_l1_data_cache.sv
// Directed plus short random bench for l1_data_cache: a word-level reference memory predicts
// read data, a pmem responder with programmable latency backs the cache and logs line traffic.
module tb_l1_data_cache;

  logic         clk;
  logic         rst;
  logic [15:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [1:0]   mem_wmask;
  logic [15:0]  mem_wdata;
  logic [15:0]  mem_rdata;
  logic         mem_resp;
  logic [15:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  l1_data_cache dut (
    .clk          (clk),
    .rst          (rst),
    .mem_address  (mem_address),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_wmask    (mem_wmask),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp),
    .pmem_address (pmem_address),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "watchdog");
  end

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] exp_q[$];

  logic [15:0] pmem_mem [32768];
  logic [15:0] ref_mem  [32768];
  int pmem_lat = 3;
  int rd_count = 0;
  int wr_count = 0;
  logic [15:0]  last_rd_addr = 16'h0;
  logic [15:0]  last_wr_addr = 16'h0;
  logic [127:0] last_wdata = 128'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] line_of(input logic [15:0] a);
    logic [127:0] l;
    int base;
    base = int'(a[15:4]) * 8;
    for (int k = 0; k < 8; k++) l[16*k +: 16] = pmem_mem[base + k];
    return l;
  endfunction

  // pmem responder: answers after pmem_lat cycles, checks output stability
  initial begin
    int cnt;
    logic [15:0]  a0;
    logic         r0;
    logic [127:0] d0;
    int base;
    cnt = 0;
    a0 = 16'h0;
    r0 = 1'b0;
    d0 = 128'h0;
    pmem_resp = 1'b0;
    pmem_rdata = 128'h0;
    forever begin
      @(negedge clk);
      if (pmem_resp) begin
        pmem_resp = 1'b0;
        cnt = 0;
      end
      if (rst || !(pmem_read || pmem_write)) begin
        cnt = 0;
      end else begin
        cnt++;
        check("pmem_rd_wr_exclusive", {31'b0, pmem_read & pmem_write}, 32'd0);
        check("mem_resp_during_miss", {31'b0, mem_resp}, 32'd0);
        if (cnt == 1) begin
          a0 = pmem_address;
          r0 = pmem_read;
          d0 = pmem_wdata;
        end else begin
          check("pmem_addr_stable", {16'b0, pmem_address}, {16'b0, a0});
          check("pmem_read_stable", {31'b0, pmem_read}, {31'b0, r0});
          check("pmem_wdata_stable", {31'b0, pmem_wdata !== d0}, 32'd0);
        end
        if (cnt >= pmem_lat) begin
          if (pmem_write) begin
            wr_count++;
            last_wr_addr = pmem_address;
            last_wdata = pmem_wdata;
            base = int'(pmem_address[15:4]) * 8;
            for (int k = 0; k < 8; k++) pmem_mem[base + k] = pmem_wdata[16*k +: 16];
          end else begin
            rd_count++;
            last_rd_addr = pmem_address;
            pmem_rdata = line_of(pmem_address);
          end
          pmem_resp = 1'b1;
        end
      end
    end
  end

  // driver: issue one CPU request at a negedge and hold it until mem_resp
  task automatic cpu_req(input logic [15:0] a, input logic rd, input logic wr,
                         input logic [1:0] m, input logic [15:0] d, output int lat);
    logic is_rd;
    logic [15:0] w;
    logic [15:0] exp;
    is_rd = rd & ~wr;
    if (is_rd) exp_q.push_back(ref_mem[a[15:1]]);
    if (wr) begin
      w = ref_mem[a[15:1]];
      if (m[0]) w[7:0] = d[7:0];
      if (m[1]) w[15:8] = d[15:8];
      ref_mem[a[15:1]] = w;
    end
    mem_address = a;
    mem_read = rd;
    mem_write = wr;
    mem_wmask = m;
    mem_wdata = d;
    #1;
    lat = 0;
    while (!mem_resp && lat < 200) begin
      @(negedge clk);
      #1;
      lat++;
    end
    if (mem_resp) begin
      if (is_rd) begin
        exp = exp_q.pop_front();
        check("rdata", {16'b0, mem_rdata}, {16'b0, exp});
      end
    end else begin
      check("resp_timeout", {31'b0, mem_resp}, 32'd1);
      if (is_rd) exp = exp_q.pop_front();
    end
    @(negedge clk);
    mem_read = 1'b0;
    mem_write = 1'b0;
  endtask

  initial begin
    int lat;
    int rd0;
    int wr0;
    int n;
    logic [15:0] ra;
    logic wr_op;
    for (int i = 0; i < 32768; i++) begin
      pmem_mem[i] = 16'(i) ^ 16'hC3A5;
    end
    pmem_mem[9] = 16'hBEEF;
    for (int i = 0; i < 32768; i++) ref_mem[i] = pmem_mem[i];

    rst = 1'b1;
    mem_address = 16'h0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    mem_wmask = 2'b00;
    mem_wdata = 16'h0;
    repeat (3) @(negedge clk);
    check("rst_mem_resp", {31'b0, mem_resp}, 32'd0);
    check("rst_pmem_read", {31'b0, pmem_read}, 32'd0);
    check("rst_pmem_write", {31'b0, pmem_write}, 32'd0);
    check("rst_pmem_address", {16'b0, pmem_address}, 32'd0);
    check("rst_mem_rdata", {16'b0, mem_rdata}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // cold miss then hit
    pmem_lat = 3;
    cpu_req(16'h0012, 1'b1, 1'b0, 2'b00, 16'h0, lat);
    check("t1_miss_latency", lat, 32'd4);
    check("t1_fill_count", rd_count, 32'd1);
    check("t1_fill_addr", {16'b0, last_rd_addr}, 32'h0010);
    cpu_req(16'h0012, 1'b1, 1'b0, 2'b00, 16'h0, lat);
    check("t1_hit_latency", lat, 32'd0);
    check("t1_no_refill", rd_count, 32'd1);

    // byte write hit, high byte only
    cpu_req(16'h0012, 1'b0, 1'b1, 2'b10, 16'h5A00, lat);
    check("t2_write_latency", lat, 32'd0);
    cpu_req(16'h0012, 1'b1, 1'b0, 2'b00, 16'h0, lat);
    check("t2_read_latency", lat, 32'd0);

    // dirty eviction of set 1
    pmem_lat = 2;
    cpu_req(16'h0092, 1'b1, 1'b0, 2'b00, 16'h0, lat);
    check("t3_latency", lat, 32'd5);
    check("t3_wb_count", wr_count, 32'd1);
    check("t3_wb_addr", {16'b0, last_wr_addr}, 32'h0010);
    check("t3_wb_word1", {16'b0, last_wdata[31:16]}, 32'h5AEF);
    check("t3_fill_addr", {16'b0, last_rd_addr}, 32'h0090);
    check("t3_fill_count", rd_count, 32'd2);

    // clean conflicts: fills only
    cpu_req(16'h0012, 1'b1, 1'b0, 2'b00, 16'h0, lat);
    check("t4a_latency", lat, 32'd3);
    cpu_req(16'h0092, 1'b1, 1'b0, 2'b00, 16'h0, lat);
    check("t4b_latency", lat, 32'd3);
    check("t4_no_writeback", wr_count, 32'd1);
    check("t4_fill_count", rd_count, 32'd4);

    // reset during ALLOCATE
    pmem_lat = 20;
    rd0 = rd_count;
    mem_address = 16'h0012;
    mem_read = 1'b1;
    n = 0;
    #1;
    while (!pmem_read && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("t5_pmem_read_seen", {31'b0, pmem_read}, 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    mem_read = 1'b0;
    #1;
    check("t5_pmem_read_drop", {31'b0, pmem_read}, 32'd0);
    check("t5_pmem_addr_zero", {16'b0, pmem_address}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t5_abandoned", rd_count, rd0);

    // slow memory refill after reset, then a no-byte write
    pmem_lat = 10;
    cpu_req(16'h0012, 1'b1, 1'b0, 2'b00, 16'h0, lat);
    check("t6_latency", lat, 32'd11);
    check("t6_fill_count", rd_count, rd0 + 1);
    wr0 = wr_count;
    cpu_req(16'h0012, 1'b0, 1'b1, 2'b00, 16'hFFFF, lat);
    check("t6_wmask0_latency", lat, 32'd0);
    cpu_req(16'h0012, 1'b1, 1'b0, 2'b00, 16'h0, lat);
    pmem_lat = 2;
    cpu_req(16'h0092, 1'b1, 1'b0, 2'b00, 16'h0, lat);
    check("t6_line_clean", wr_count, wr0);
    check("t6_conflict_latency", lat, 32'd3);

    // random mix over four tags
    for (int i = 0; i < 40; i++) begin
      pmem_lat = $urandom_range(1, 4);
      ra = {7'd0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), 1'b0};
      wr_op = ($urandom_range(0, 2) == 0);
      if (wr_op)
        cpu_req(ra, 1'($urandom_range(0, 1)), 1'b1, 2'($urandom_range(0, 3)),
                16'($urandom_range(0, 65535)), lat);
      else
        cpu_req(ra, 1'b1, 1'b0, 2'b00, 16'h0, lat);
    end

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
